// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet winner-take-all front end.
package maxnet_pkg;

    localparam int FP_W   = 32;
    localparam int NUM_IN = 4;

    localparam logic [FP_W-1:0] FP_POS_MAX = 32'h7F7F_FFFF;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/fp_nonneg_clamp.sv
// Maps an IEEE-754 single onto a non-negative finite value: negatives and NaN
// become +0, +inf becomes the largest finite positive value.
module fp_nonneg_clamp
    import maxnet_pkg::*;
(
    input  logic [FP_W-1:0] word,
    output logic [FP_W-1:0] clean
);

    logic [7:0]  exponent;
    logic [22:0] mantissa;

    assign exponent = word[30:23];
    assign mantissa = word[22:0];

    always_comb begin
        clean = word;
        if (word[31]) begin
            clean = '0;
        end else if (exponent == 8'hFF) begin
            clean = (mantissa != '0) ? '0 : FP_POS_MAX;
        end
    end

endmodule

// File: rtl/maxnet_loader.sv
// Buffers four sanitised activations, launches Maxnet, waits for done (with a
// timeout guard) and hands the captured result downstream.
module maxnet_loader
    import maxnet_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [FP_W-1:0] X1,
    output logic [FP_W-1:0] X2,
    output logic [FP_W-1:0] X3,
    output logic [FP_W-1:0] X4,
    output logic            start,
    input  logic            done,
    input  logic [FP_W-1:0] result,
    output logic [FP_W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err,
    output logic            busy
);

    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [1:0]    CLAST = 2'(NUM_IN - 1);

    state_t          state;
    state_t          next_state;
    logic [1:0]      cnt;
    logic [TW-1:0]   tcnt;
    logic [FP_W-1:0] clean;
    logic [FP_W-1:0] slot [NUM_IN];
    logic            accept;
    logic            timeout_hit;

    fp_nonneg_clamp u_clamp (
        .word  (in_data),
        .clean (clean)
    );

    assign accept      = in_valid & in_ready;
    assign timeout_hit = (tcnt == TLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (accept && cnt == CLAST) next_state = LAUNCH;
            LAUNCH:  next_state = WAIT;
            WAIT:    if (done || timeout_hit) next_state = OUTPUT;
            OUTPUT:  if (out_ready) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL);
        start     = (state == LAUNCH);
        out_valid = (state == OUTPUT);
        busy      = (state != FILL);
    end

    // Slot writes, timeout counting and result capture; done beats timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            tcnt     <= '0;
            out_data <= '0;
            err      <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) slot[i] <= '0;
        end else begin
            if (accept) begin
                slot[cnt] <= clean;
                cnt       <= cnt + 2'd1;
            end
            if (state == LAUNCH) begin
                tcnt <= '0;
            end else if (state == WAIT && !done) begin
                tcnt <= tcnt + TW'(1);
            end
            if (state == WAIT) begin
                if (done) begin
                    out_data <= result;
                    err      <= 1'b0;
                end else if (timeout_hit) begin
                    out_data <= '0;
                    err      <= 1'b1;
                end
            end
        end
    end

    assign X1 = slot[0];
    assign X2 = slot[1];
    assign X3 = slot[2];
    assign X4 = slot[3];

endmodule

// File: tb/tb_maxnet_loader.sv
// Self-checking bench for maxnet_loader: table vectors, randomized batches
// against a reference sanitiser, plus timeout, stale-done and reset sequences.
module tb_maxnet_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data, result, out_data, X1, X2, X3, X4;
    logic        in_valid, in_ready, start, done, out_valid, out_ready, err, busy;

    logic [31:0] t_in_data, t_result, t_out_data, t_X1, t_X2, t_X3, t_X4;
    logic        t_in_valid, t_in_ready, t_start, t_done, t_out_valid, t_out_ready, t_err, t_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maxnet_loader #(.TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .X1(X1), .X2(X2), .X3(X3), .X4(X4), .start(start), .done(done), .result(result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .err(err), .busy(busy)
    );

    maxnet_loader #(.TIMEOUT(15)) dut_to (
        .clk(clk), .rst(rst), .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .X1(t_X1), .X2(t_X2), .X3(t_X3), .X4(t_X4), .start(t_start), .done(t_done),
        .result(t_result), .out_data(t_out_data), .out_valid(t_out_valid),
        .out_ready(t_out_ready), .err(t_err), .busy(t_busy)
    );

    typedef struct {
        logic [31:0] w [4];
        logic [31:0] x [4];
        logic [31:0] res;
        int          delay;
        int          stall;
        bit          randvalid;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference sanitiser: negatives and NaN -> +0, +inf -> largest finite.
    function automatic logic [31:0] ref_clean(input logic [31:0] w);
        if (w[31]) return 32'h0;
        if (w[30:23] == 8'hFF) return (w[22:0] == 23'h0) ? 32'h7F7FFFFF : 32'h0;
        return w;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, b, c, d, xa, xb, xc, xd,
                                input logic [31:0] res, input int delay, stall, input bit rv);
        vec_t v;
        v.w[0] = a;  v.w[1] = b;  v.w[2] = c;  v.w[3] = d;
        v.x[0] = xa; v.x[1] = xb; v.x[2] = xc; v.x[3] = xd;
        v.res = res; v.delay = delay; v.stall = stall; v.randvalid = rv;
        return v;
    endfunction

    task automatic chk_x(input string tag, input logic [31:0] x [4]);
        chk({tag, "_X1"}, X1, x[0]);
        chk({tag, "_X2"}, X2, x[1]);
        chk({tag, "_X3"}, X3, x[2]);
        chk({tag, "_X4"}, X4, x[3]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_X1"}, X1, 32'd0);
        chk({tag, "_X2"}, X2, 32'd0);
        chk({tag, "_X3"}, X3, 32'd0);
        chk({tag, "_X4"}, X4, 32'd0);
    endtask

    task automatic feed(input logic [31:0] w [4], input bit rv);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; rv && k < 6 && $urandom_range(0, 1) == 1; k++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                step();
                chk("fill_in_ready", 32'(in_ready), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic run_batch(input string tag, input vec_t v);
        chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        feed(v.w, v.randvalid);
        chk({tag, "_start"}, 32'(start), 32'd1);
        chk({tag, "_launch_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_launch_busy"}, 32'(busy), 32'd1);
        chk_x(tag, v.x);
        step();
        chk({tag, "_start_one_cycle"}, 32'(start), 32'd0);
        for (int d = 0; d < v.delay; d++) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            result   = $urandom;
            step();
            chk({tag, "_wait_out_valid"}, 32'(out_valid), 32'd0);
            chk({tag, "_wait_in_ready"}, 32'(in_ready), 32'd0);
        end
        done   = 1'b1;
        result = v.res;
        step();
        done   = 1'b0;
        result = $urandom;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_data"}, out_data, v.res);
        chk({tag, "_err"}, 32'(err), 32'd0);
        for (int s = 0; s < v.stall; s++) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            step();
            chk({tag, "_stall_out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_out_data"}, out_data, v.res);
            chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_drain_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
        chk_x({tag, "_held"}, v.x);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h7F800000;
            1: return 32'hFF800000;
            2: return 32'h7F800000 | 32'($urandom_range(1, 32'h7FFFFF));
            3: return 32'h80000000;
            4: return 32'h7F7FFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic t_launch(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            t_in_valid = 1'b1;
            t_in_data  = base + 32'(i);
            step();
        end
        t_in_valid = 1'b0;
        chk("to_start", 32'(t_start), 32'd1);
        step();
    endtask

    initial begin
        vec_t        v;
        logic [31:0] nw [4];

        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; done = 1'b0; result = '0; out_ready = 1'b0;
        t_in_data = '0; t_in_valid = 1'b0; t_done = 1'b0; t_result = '0; t_out_ready = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        vecs[0] = mk(32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD,
                     32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD,
                     32'h3F000000, 30, 0, 1'b0);
        vecs[1] = mk(32'hBF000000, 32'h7FC00000, 32'h7F800000, 32'h80000000,
                     32'h00000000, 32'h00000000, 32'h7F7FFFFF, 32'h00000000,
                     32'h3F800000, 3, 2, 1'b0);
        vecs[2] = mk(32'h00000000, 32'h7F7FFFFF, 32'h00000001, 32'h7F800001,
                     32'h00000000, 32'h7F7FFFFF, 32'h00000001, 32'h00000000,
                     32'h40490FDB, 5, 10, 1'b1);
        vecs[3] = mk(32'h7FFFFFFF, 32'hFF800000, 32'h00800000, 32'h3F800000,
                     32'h00000000, 32'h00000000, 32'h00800000, 32'h3F800000,
                     32'h12345678, 0, 1, 1'b1);
        for (int i = 0; i < 4; i++) run_batch($sformatf("vec%0d", i), vecs[i]);

        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 4; i++) begin
                v.w[i] = rand_word();
                v.x[i] = ref_clean(v.w[i]);
            end
            v.res       = $urandom;
            v.delay     = $urandom_range(0, 20);
            v.stall     = $urandom_range(0, 5);
            v.randvalid = 1'b1;
            run_batch($sformatf("rand%0d", b), v);
        end

        // Stale done held high from FILL through LAUNCH.
        done   = 1'b1;
        result = 32'h3DCCCCCD;
        for (int i = 0; i < 4; i++) nw[i] = 32'h3F000000 + 32'(i);
        feed(nw, 1'b0);
        chk("stale_start", 32'(start), 32'd1);
        chk("stale_launch_out_valid", 32'(out_valid), 32'd0);
        step();
        chk("stale_wait_out_valid", 32'(out_valid), 32'd0);
        step();
        chk("stale_out_valid", 32'(out_valid), 32'd1);
        chk("stale_out_data", out_data, 32'h3DCCCCCD);
        done      = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stale_drain_in_ready", 32'(in_ready), 32'd1);

        // Reset after two inputs, asserted between clock edges.
        in_valid = 1'b1; in_data = 32'h11111111; step();
        in_valid = 1'b1; in_data = 32'h22222222; step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        step();
        rst = 1'b0;
        step();
        v = mk(32'h3A000000, 32'h3B000000, 32'h3C000000, 32'h3D000000,
               32'h3A000000, 32'h3B000000, 32'h3C000000, 32'h3D000000,
               32'h3E000000, 2, 0, 1'b0);
        run_batch("after_rst", v);

        // Timeout with done never asserted: out_valid 15 cycles after entering WAIT.
        t_launch(32'h3F800000);
        for (int k = 1; k < 15; k++) begin
            step();
            chk("to_wait_out_valid", 32'(t_out_valid), 32'd0);
        end
        step();
        chk("to_out_valid", 32'(t_out_valid), 32'd1);
        chk("to_err", 32'(t_err), 32'd1);
        chk("to_out_data", t_out_data, 32'd0);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("to_stall_err", 32'(t_err), 32'd1);
            chk("to_stall_in_ready", 32'(t_in_ready), 32'd0);
        end
        t_out_ready = 1'b1;
        step();
        t_out_ready = 1'b0;
        chk("to_drain_in_ready", 32'(t_in_ready), 32'd1);

        // done arriving in the same cycle as the timeout wins.
        t_launch(32'h40000000);
        for (int k = 1; k < 15; k++) step();
        t_done   = 1'b1;
        t_result = 32'hABCD1234;
        step();
        t_done = 1'b0;
        chk("tie_out_valid", 32'(t_out_valid), 32'd1);
        chk("tie_err", 32'(t_err), 32'd0);
        chk("tie_out_data", t_out_data, 32'hABCD1234);
        t_out_ready = 1'b1;
        step();
        t_out_ready = 1'b0;
        chk("tie_drain_in_ready", 32'(t_in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_loader.md
# maxnet_loader

Upstream sequencer for the Maxnet winner-take-all stage. Accepts a serial stream of IEEE-754 single-precision activations over a valid/ready handshake and buffers four of them. Once the buffer is full it drives the Maxnet X1..X4 inputs and issues the start pulse. It then waits for done, captures result, and presents it downstream over a second valid/ready handshake, with a timeout guard against a stuck Maxnet.

## Interface
Parameters:
- TIMEOUT, 1023: maximum cycles spent in WAIT before aborting with err.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  32  activation word, IEEE-754 single.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a word.
- X1, X2, X3, X4  out  32 each  sanitised activations to Maxnet; X1 is the first word accepted.
- start  out  1  one-cycle launch pulse to Maxnet.
- done  in  1  Maxnet completion (level or pulse).
- result  in  32  Maxnet output, sampled when done is accepted.
- out_data  out  32  captured result, or 0 on timeout.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- err  out  1  timeout flag; qualified by out_valid.
- busy  out  1  high in every state except FILL.

## Operation
- State machine: FILL, LAUNCH, WAIT, OUTPUT.
- FILL:
  - in_ready = 1.
  - A transfer occurs when in_valid & in_ready; the sanitised word is written to slot cnt (0..3) and cnt is incremented.
  - The transfer with cnt = 3 moves the FSM to LAUNCH and wraps cnt to 0.
- Sanitise rule, applied at capture:
  - Sign bit set (any negative, including -0): word becomes 0x00000000.
  - NaN (exponent 0xFF, mantissa ≠ 0): word becomes 0x00000000.
  - +inf: word becomes 0x7F7FFFFF.
  - Any other value passes unchanged.
  - Maxnet requires non-negative finite activations, which is why this rule exists.
- LAUNCH: start = 1 for exactly this cycle, in_ready = 0. Next state is WAIT, and the timeout counter is cleared.
- WAIT:
  - done is sampled every cycle.
  - On done = 1: result goes to out_data, err = 0, next state OUTPUT.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT: out_data = 0, err = 1, next state OUTPUT.
  - done = 1 in the same cycle as the timeout: done wins.
- OUTPUT:
  - out_valid = 1, and out_data and err are held stable until out_valid & out_ready.
  - On that handshake: out_valid = 0, next state FILL.
- X1..X4 are registers. They change only on FILL writes and are stable from LAUNCH until the next FILL write.
- done is ignored outside WAIT, including in the LAUNCH cycle. A stale done held high from a previous batch is therefore first seen in WAIT, one cycle after start; Maxnet clears done on start.
- Reset, at any time including mid-batch: the FSM returns to FILL and cnt = 0. Partial data is discarded.

## Timing
- Reset values: in_ready = 1, start = 0, out_valid = 0, err = 0, busy = 0, out_data = 0, X1..X4 = 0.
- Fourth input transfer at edge N: LAUNCH during cycle N..N+1, so start is high one cycle after the fourth accept.
- done accepted at edge M: out_valid rises at M.
- Minimum turnaround: out_ready high at the first out_valid cycle gives in_ready = 1 on the following cycle.
- No input is accepted while busy. No back-to-back batch overlap.
- TIMEOUT counter width is $clog2(TIMEOUT+1).

## Structure
- Package maxnet_pkg holds:
  - FP_W = 32 and NUM_IN = 4.
  - The state enum {FILL, LAUNCH, WAIT, OUTPUT}.
  - FP_POS_MAX = 32'h7F7FFFFF.
- Sub-module fp_nonneg_clamp: purely combinational, 32-bit in and 32-bit out, implementing the sanitise rule. It is reused by later Maxnet-adjacent stages.
- Top-level maxnet_loader contains the FSM, the slot counter, the four slot registers, the timeout counter and the output register.

## Test plan
- Basic batch:
  - Stimulus: stream 0x3E4CCCCD, 0x3ECCCCCD, 0x3F19999A, 0x3F4CCCCD; done pulsed with result = 0x3F000000 after 30 cycles.
  - Required: X1..X4 equal the words in order, start high one cycle, out_data = 0x3F000000, err = 0.
- Sanitise:
  - Stimulus: inputs 0xBF000000, 0x7FC00000, 0x7F800000, 0x80000000.
  - Required: X1 = 0, X2 = 0, X3 = 0x7F7FFFFF, X4 = 0.
- Backpressure:
  - Stimulus: in_valid toggled randomly; out_ready held low 10 cycles after out_valid.
  - Required: no lost or duplicated words, out_data stable while stalled, in_ready = 0 throughout.
- Timeout:
  - Stimulus: TIMEOUT = 15, done never asserted.
  - Required: out_valid with err = 1 and out_data = 0 exactly 15 cycles after entering WAIT.
- Stale done:
  - Stimulus: done held high through LAUNCH.
  - Required: done is not accepted in LAUNCH; it is accepted in the first WAIT cycle, so out_valid rises two cycles after start.
- Reset mid-batch:
  - Stimulus: assert rst after two inputs; then stream four new words.
  - Required: all outputs at reset values immediately; the next batch's X1 is the first new word.
